// File: rtl/sync_ram.sv
// Single-port synchronous RAM with req/ready handshake, per-lane write enables,
// a 1- or 2-cycle registered read pipeline and a zero-fill sequence after reset.
module sync_ram #(
    parameter int unsigned addr_size  = 10,
    parameter int unsigned word_size  = 32,
    parameter int unsigned lane_size  = 8,
    parameter int unsigned mem_size   = 1024,
    parameter int unsigned rd_latency = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req,
    input  logic                           wr,
    input  logic [addr_size-1:0]           addr,
    input  logic [word_size-1:0]           data_in,
    input  logic [word_size/lane_size-1:0] be,
    output logic                           ready,
    output logic                           rd_valid,
    output logic [word_size-1:0]           data_out,
    output logic                           init_done,
    output logic                           addr_err
);

    localparam int unsigned lanes = word_size / lane_size;
    localparam int unsigned idx_w = (mem_size > 1) ? $clog2(mem_size) : 1;
    localparam logic [idx_w-1:0] last_idx = idx_w'(mem_size - 1);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e                 state;
    logic [idx_w-1:0]       fill_cnt;
    logic [word_size-1:0]   mem [mem_size];

    logic [word_size-1:0]   pipe_data [rd_latency];
    logic [rd_latency-1:0]  pipe_valid;

    logic                   accept;
    logic                   in_range;
    logic [idx_w-1:0]       idx;

    // ready is registered, so acceptance never depends combinationally on req
    assign accept   = req && ready;
    assign in_range = 32'(addr) < mem_size;
    assign idx      = addr[idx_w-1:0];

    // Control FSM: sweep the fill counter in INIT, then sit in RUN until reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StInit;
            fill_cnt  <= '0;
            ready     <= 1'b0;
            init_done <= 1'b0;
        end else begin
            case (state)
                StInit: begin
                    if (fill_cnt == last_idx) begin
                        state     <= StRun;
                        ready     <= 1'b1;
                        init_done <= 1'b1;
                    end else begin
                        fill_cnt <= fill_cnt + idx_w'(1);
                    end
                end
                StRun: begin
                    ready     <= 1'b1;
                    init_done <= 1'b1;
                end
                default: state <= StInit;
            endcase
        end
    end

    // Array write port: zero-fill during INIT, lane-masked writes during RUN
    always_ff @(posedge clk) begin
        if (state == StInit) begin
            mem[fill_cnt] <= '0;
        end else if (accept && wr && in_range) begin
            for (int i = 0; i < lanes; i++) begin
                if (be[i]) begin
                    mem[idx][i*lane_size +: lane_size] <= data_in[i*lane_size +: lane_size];
                end
            end
        end
    end

    // Read pipeline and status pulses; reset drops any read still in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < rd_latency; i++) begin
                pipe_data[i] <= '0;
            end
            pipe_valid <= '0;
            rd_valid   <= 1'b0;
            data_out   <= '0;
            addr_err   <= 1'b0;
        end else begin
            addr_err      <= accept && !in_range;
            pipe_valid[0] <= accept && !wr;
            if (accept && !wr) begin
                // Out-of-range reads complete normally but return zero
                pipe_data[0] <= in_range ? mem[idx] : '0;
            end
            for (int i = 1; i < rd_latency; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
            rd_valid <= pipe_valid[rd_latency-1];
            if (pipe_valid[rd_latency-1]) begin
                data_out <= pipe_data[rd_latency-1];
            end
        end
    end

endmodule

// File: tb/tb_sync_ram.sv
// Scoreboard bench for sync_ram: two instances (16 words / latency 1 and
// 1000 words / latency 2) share one stimulus stream; a negedge monitor pops
// expected read data and addr_err pulses per instance.
module tb_sync_ram;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] data_in;
    logic [3:0]  be;

    logic        ready_a, rd_valid_a, init_done_a, addr_err_a;
    logic [31:0] data_out_a;
    logic        ready_b, rd_valid_b, init_done_b, addr_err_b;
    logic [31:0] data_out_b;

    always #5 clk = ~clk;

    sync_ram #(
        .addr_size (10),
        .word_size (32),
        .lane_size (8),
        .mem_size  (16),
        .rd_latency(1)
    ) dut_a (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .wr       (wr),
        .addr     (addr),
        .data_in  (data_in),
        .be       (be),
        .ready    (ready_a),
        .rd_valid (rd_valid_a),
        .data_out (data_out_a),
        .init_done(init_done_a),
        .addr_err (addr_err_a)
    );

    sync_ram #(
        .addr_size (10),
        .word_size (32),
        .lane_size (8),
        .mem_size  (1000),
        .rd_latency(2)
    ) dut_b (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .wr       (wr),
        .addr     (addr),
        .data_in  (data_in),
        .be       (be),
        .ready    (ready_b),
        .rd_valid (rd_valid_b),
        .data_out (data_out_b),
        .init_done(init_done_b),
        .addr_err (addr_err_b)
    );

    typedef struct {
        int          side;
        int          due;
        logic [31:0] data;
    } rd_exp_t;

    typedef struct {
        int   side;
        int   due;
        logic val;
    } err_exp_t;

    rd_exp_t  rd_q[$];
    err_exp_t err_q[$];
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endfunction

    // Monitor for one instance: match rd_valid and addr_err against the queues
    task automatic mon(input int s, input logic v, input logic [31:0] d, input logic e);
        int ri = -1;
        int ei = -1;
        foreach (rd_q[i]) if (ri < 0 && rd_q[i].side == s) ri = i;
        foreach (err_q[i]) if (ei < 0 && err_q[i].side == s) ei = i;
        if (v) begin
            if (ri < 0) begin
                fail($sformatf("rd_unexpected_%0d", s));
            end else begin
                check($sformatf("rd_due_%0d", s), cyc, rd_q[ri].due);
                check($sformatf("rd_data_%0d", s), d, rd_q[ri].data);
                rd_q.delete(ri);
            end
        end else if (ri >= 0 && rd_q[ri].due <= cyc) begin
            fail($sformatf("rd_missing_%0d", s));
            rd_q.delete(ri);
        end
        if (ei >= 0 && err_q[ei].due == cyc) begin
            check($sformatf("addr_err_%0d", s), e, err_q[ei].val);
            err_q.delete(ei);
        end else if (e) begin
            fail($sformatf("addr_err_unexpected_%0d", s));
        end
    endtask

    always @(negedge clk) begin
        mon(0, rd_valid_a, data_out_a, addr_err_a);
        mon(1, rd_valid_b, data_out_b, addr_err_b);
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Issue one request (caller sits at posedge+2 with both instances ready)
    task automatic do_req(input logic w, input logic [9:0] a, input logic [31:0] d,
                          input logic [3:0] b, input logic [31:0] exp);
        int n;
        req     = 1'b1;
        wr      = w;
        addr    = a;
        data_in = d;
        be      = b;
        @(posedge clk);
        #2;
        n = cyc;
        err_q.push_back('{side: 0, due: n, val: (a >= 10'd16)});
        err_q.push_back('{side: 1, due: n, val: (a >= 10'd1000)});
        if (!w) begin
            rd_q.push_back('{side: 0, due: n + 1, data: (a >= 10'd16) ? 32'h0 : exp});
            rd_q.push_back('{side: 1, due: n + 2, data: (a >= 10'd1000) ? 32'h0 : exp});
        end
        req = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        req     = 1'b0;
        wr      = 1'b0;
        addr    = '0;
        data_in = '0;
        be      = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_ctrl_a", {28'h0, ready_a, init_done_a, rd_valid_a, addr_err_a}, 32'h0);
        check("rst_ctrl_b", {28'h0, ready_b, init_done_b, rd_valid_b, addr_err_b}, 32'h0);
        check("rst_dout_a", data_out_a, 32'h0);
        check("rst_dout_b", data_out_b, 32'h0);

        // Release reset; hold a write to addr 3 during INIT, which must be ignored
        rst     = 1'b0;
        req     = 1'b1;
        wr      = 1'b1;
        addr    = 10'd3;
        data_in = 32'hFFFF_FFFF;
        be      = 4'hF;
        for (int k = 1; k <= 1000; k++) begin
            @(posedge clk);
            #2;
            if (k == 10) req = 1'b0;
            if (k == 15) check("ready_a_e15", {31'h0, ready_a}, 32'h0);
            if (k == 16) begin
                check("ready_a_e16", {30'h0, ready_a, init_done_a}, 32'h3);
                check("ready_b_e16", {31'h0, ready_b}, 32'h0);
            end
            if (k == 999) check("ready_b_e999", {31'h0, ready_b}, 32'h0);
            if (k == 1000) check("ready_b_e1000", {30'h0, ready_b, init_done_b}, 32'h3);
        end

        // Every word reads zero after the fill
        for (int i = 0; i < 16; i++) do_req(1'b0, 10'(i), 32'h0, 4'h0, 32'h0);

        // Lane-masked merge
        do_req(1'b1, 10'd5, 32'hDEAD_BEEF, 4'b1111, 32'h0);
        do_req(1'b1, 10'd5, 32'h1122_3344, 4'b0101, 32'h0);
        do_req(1'b0, 10'd5, 32'h0, 4'hF, 32'hDE22_BE44);

        // Preload value=addr, then eight back-to-back reads
        for (int i = 0; i < 8; i++) do_req(1'b1, 10'(i), 32'(i), 4'hF, 32'h0);
        for (int i = 0; i < 8; i++) do_req(1'b0, 10'(i), 32'h0, 4'h0, 32'(i));

        // be=0 write is a no-op
        do_req(1'b1, 10'd6, 32'hFFFF_FFFF, 4'h0, 32'h0);
        do_req(1'b0, 10'd6, 32'h0, 4'h0, 32'd6);

        // Read the cycle after a write to the same address
        do_req(1'b1, 10'd3, 32'hCAFE_F00D, 4'hF, 32'h0);
        do_req(1'b0, 10'd3, 32'h0, 4'h0, 32'hCAFE_F00D);

        // Out-of-range write and read; no aliasing into the array
        do_req(1'b1, 10'd1010, 32'hAAAA_5555, 4'hF, 32'h0);
        do_req(1'b0, 10'd1010, 32'h0, 4'h0, 32'h0);
        do_req(1'b0, 10'd2, 32'h0, 4'h0, 32'd2);
        do_req(1'b0, 10'd498, 32'h0, 4'h0, 32'h0);
        do_req(1'b0, 10'd999, 32'h0, 4'h0, 32'h0);
        do_req(1'b0, 10'd7, 32'h0, 4'h0, 32'd7);

        // data_out holds between reads
        idle(4);
        check("hold_a", data_out_a, 32'd7);
        check("hold_b", data_out_b, 32'd7);

        // Reset with a read in flight: it is dropped and memory is re-zeroed
        do_req(1'b0, 10'd5, 32'h0, 4'h0, 32'd5);
        rst = 1'b1;
        rd_q.delete();
        err_q.delete();
        #1;
        check("midrst_a", {rd_valid_a, data_out_a[30:0]}, 32'h0);
        check("midrst_b", {rd_valid_b, data_out_b[30:0]}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int k = 0; k < 1100 && !(ready_a && ready_b); k++) idle(1);
        check("reinit_ready", {30'h0, ready_a, ready_b}, 32'h3);
        check("reinit_dout", data_out_a | data_out_b, 32'h0);
        do_req(1'b0, 10'd5, 32'h0, 4'h0, 32'h0);
        do_req(1'b0, 10'd3, 32'h0, 4'h0, 32'h0);

        idle(5);
        check("drain", 32'(rd_q.size() + err_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
